// File: rtl/datapath_pkg.sv
// Shared types and ALU opcode encodings for the datapath.
package datapath_pkg;

  typedef logic [31:0] word_t;
  typedef logic [63:0] result_t;

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpShr  = 5'b00111;
  localparam logic [4:0] OpShra = 5'b01000;
  localparam logic [4:0] OpShl  = 5'b01001;
  localparam logic [4:0] OpRor  = 5'b01010;
  localparam logic [4:0] OpRol  = 5'b01011;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A from Y, B from the bus, 64-bit result for Z.
// Signed mul/div exist only when DATAPATH_MULDIV_EN is defined.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  opcode,
  output logic [63:0] result
);

  logic [4:0] amt;
  result_t    rot_r;
  result_t    rot_l;

  assign amt = b[4:0];
  // Rotates shift a doubled copy so an amount of 0 naturally passes A through.
  assign rot_r = {a, a} >> amt;
  assign rot_l = {a, a} << amt;

`ifdef DATAPATH_MULDIV_EN
  result_t            prod;
  logic signed [31:0] quo;
  logic signed [31:0] rem;

  assign prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign quo  = $signed(a) / $signed(b);
  assign rem  = $signed(a) % $signed(b);
`endif

  always_comb begin
    result = '0;
    case (opcode)
      OpAdd:  result = {32'b0, a + b};
      OpSub:  result = {32'b0, a - b};
      OpAnd:  result = {32'b0, a & b};
      OpOr:   result = {32'b0, a | b};
      OpShr:  result = {32'b0, a >> amt};
      OpShra: result = {32'b0, word_t'($signed(a) >>> amt)};
      OpShl:  result = {32'b0, a << amt};
      OpRor:  result = {32'b0, rot_r[31:0]};
      OpRol:  result = {32'b0, rot_l[63:32]};
      OpNeg:  result = {32'b0, word_t'(-b)};
      OpNot:  result = {32'b0, ~b};
`ifdef DATAPATH_MULDIV_EN
      OpMul:  result = prod;
      OpDiv:  result = (b == '0) ? {a, 32'hFFFF_FFFF} : {word_t'(rem), word_t'(quo)};
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Register file, special registers, 64-bit Z and the prioritised bus mux.
// Build with DATAPATH_MULDIV_EN to enable signed multiply/divide in the ALU.
module datapath
  import datapath_pkg::*;
(
  input  logic        Clock,
  input  logic        clear_n,
  input  logic [31:0] Mdatain,
  input  logic        Read,
  input  logic        IncPC,
  input  logic [15:0] Rin,
  input  logic [15:0] Rout,
  input  logic        PCin,
  input  logic        Zin,
  input  logic        MDRin,
  input  logic        MARin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        IRin,
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        MDRout,
  input  logic        Cout,
  input  logic [4:0]  opcode
);

  word_t   r_q [16];
  word_t   pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q;
  result_t z_q;
  word_t   bus;
  result_t alu_result;

  always_comb begin
    bus = '0;
    if (MDRout)        bus = mdr_q;
    else if (PCout)    bus = pc_q;
    else if (Zhighout) bus = z_q[63:32];
    else if (Zlowout)  bus = z_q[31:0];
    else if (HIout)    bus = hi_q;
    else if (LOout)    bus = lo_q;
    else if (Cout)     bus = {{13{ir_q[18]}}, ir_q[18:0]};
    else begin
      // Walk downwards so the lowest selected register wins.
      for (int i = 15; i >= 0; i--) begin
        if (Rout[i]) bus = r_q[i];
      end
    end
  end

  datapath_alu u_alu (
    .a      (y_q),
    .b      (bus),
    .opcode (opcode),
    .result (alu_result)
  );

  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (Rin[i]) r_q[i] <= bus;
      end
      if (PCin)  pc_q  <= IncPC ? pc_q + 32'd1 : bus;
      if (MDRin) mdr_q <= Read ? Mdatain : bus;
      if (MARin) mar_q <= bus;
      if (Yin)   y_q   <= bus;
      if (HIin)  hi_q  <= bus;
      if (LOin)  lo_q  <= bus;
      if (IRin)  ir_q  <= bus;
      if (Zin)   z_q   <= alu_result;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed vectors, hand sequences and random ALU ops.
module tb_datapath;
  import datapath_pkg::*;

  logic        Clock = 1'b0;
  logic        clear_n;
  logic [31:0] Mdatain;
  logic        Read, IncPC;
  logic [15:0] Rin, Rout;
  logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin;
  logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout;
  logic [4:0]  opcode;

  int checks = 0;
  int errors = 0;

`ifdef DATAPATH_MULDIV_EN
  localparam bit MulDiv = 1'b1;
`else
  localparam bit MulDiv = 1'b0;
`endif

  datapath dut (
    .Clock(Clock), .clear_n(clear_n), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .IRin(IRin), .PCout(PCout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .Cout(Cout), .opcode(opcode)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    Mdatain = '0; Read = 0; IncPC = 0; Rin = '0; Rout = '0; opcode = '0;
    {PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin} = '0;
    {PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout} = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
  endtask

  // Y <- a, then Z <- alu(op, Y, b) with b on the bus from MDR.
  task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    load_mdr(a);
    MDRout = 1; Yin = 1;
    tick();
    load_mdr(b);
    MDRout = 1; Zin = 1; opcode = op;
    tick();
  endtask

  // Reference ALU built from the operation definitions with wide integer arithmetic.
  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned n;
    longint      sa, sb, q, r;
    logic [31:0] w;
    n  = b % 32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    w  = a;
    case (op)
      OpAdd:  return {32'b0, 32'((longint'(a) + longint'(b)) % (64'd1 << 32))};
      OpSub:  return {32'b0, 32'(longint'(a) - longint'(b))};
      OpAnd:  return {32'b0, a & b};
      OpOr:   return {32'b0, a | b};
      OpShr:  return {32'b0, 32'(longint'(a) / (longint'(1) << n))};
      OpShra: begin
        for (int i = 0; i < int'(n); i++) w = {w[31], w[31:1]};
        return {32'b0, w};
      end
      OpShl:  return {32'b0, 32'(longint'(a) * (longint'(1) << n))};
      OpRor: begin
        for (int i = 0; i < int'(n); i++) w = {w[0], w[31:1]};
        return {32'b0, w};
      end
      OpRol: begin
        for (int i = 0; i < int'(n); i++) w = {w[30:0], w[31]};
        return {32'b0, w};
      end
      OpNeg:  return {32'b0, 32'(0 - sb)};
      OpNot:  return {32'b0, 32'hFFFF_FFFF ^ b};
      OpMul:  return MulDiv ? 64'(sa * sb) : 64'd0;
      OpDiv: begin
        if (!MulDiv) return 64'd0;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa - q * sb;
        return {32'(r), 32'(q)};
      end
      default: return 64'd0;
    endcase
  endfunction

  logic [4:0]  ops [13] = '{OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShra, OpShl, OpRor, OpRol,
                            OpMul, OpDiv, OpNeg, OpNot};

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    int          k;

    idle();
    clear_n = 0;
    #2;
    for (int i = 0; i < 16; i++) check($sformatf("reset_r%0d", i), 64'(dut.r_q[i]), 64'd0);
    check("reset_pc", 64'(dut.pc_q), 64'd0);
    check("reset_z", dut.z_q, 64'd0);
    check("reset_misc", 64'(dut.ir_q | dut.mar_q | dut.mdr_q | dut.y_q | dut.hi_q | dut.lo_q),
          64'd0);
    #5 clear_n = 1;
    @(negedge Clock);

    // PC/IR fetch sequence
    PCout = 1; MARin = 1; tick();
    check("mar_from_pc", 64'(dut.mar_q), 64'd0);
    PCin = 1; IncPC = 1; tick();
    check("pc_inc", 64'(dut.pc_q), 64'd1);
    load_mdr(32'h2891_8000);
    MDRout = 1; IRin = 1; tick();
    check("ir_load", 64'(dut.ir_q), 64'h2891_8000);
    Cout = 1; Rin = 16'h0008; tick();
    check("cout_pos", 64'(dut.r_q[3]), 64'h0001_8000);

    // Bus priority and multi-load
    load_mdr(32'hA0); MDRout = 1; Rin = 16'h0001; tick();
    load_mdr(32'hA5); MDRout = 1; Rin = 16'h0020; tick();
    Rout = 16'h0021; Yin = 1; tick();
    check("prio_r0_over_r5", 64'(dut.y_q), 64'hA0);
    MDRout = 1; PCout = 1; Yin = 1; tick();
    check("prio_mdr_over_pc", 64'(dut.y_q), 64'hA5);
    PCout = 1; Zhighout = 1; Rout = 16'h0001; Yin = 1; tick();
    check("prio_pc_over_z", 64'(dut.y_q), 64'd1);
    MDRout = 1; Rin = 16'h0006; tick();
    check("multi_rin", {dut.r_q[1], dut.r_q[2]}, {32'hA5, 32'hA5});
    Yin = 1; tick();
    check("bus_idle_zero", 64'(dut.y_q), 64'd0);
    load_mdr(32'h0007_FFFF); MDRout = 1; IRin = 1; tick();
    Cout = 1; Rin = 16'h0004; tick();
    check("cout_signext", 64'(dut.r_q[2]), 64'hFFFF_FFFF);

    // PC wraps on increment
    load_mdr(32'hFFFF_FFFF); MDRout = 1; PCin = 1; tick();
    PCin = 1; IncPC = 1; tick();
    check("pc_wrap", 64'(dut.pc_q), 64'd0);

    // Directed ALU vectors
    vecs.push_back('{"shr4",    OpShr,  32'h8000_0012, 32'd4,  64'h0000_0000_0800_0001});
    vecs.push_back('{"shra4",   OpShra, 32'h8000_0012, 32'd4,  64'h0000_0000_F800_0001});
    vecs.push_back('{"mul",     OpMul,  32'hFFFF_FFFE, 32'd3,  64'hFFFF_FFFF_FFFF_FFFA});
    vecs.push_back('{"div_neg", OpDiv,  32'hFFFF_FFF9, 32'd2,  64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{"div0",    OpDiv,  32'd5,         32'd0,  64'h0000_0005_FFFF_FFFF});
    vecs.push_back('{"add_wrap", OpAdd, 32'hFFFF_FFFF, 32'd2,  64'h0000_0000_0000_0001});
    vecs.push_back('{"sub_wrap", OpSub, 32'd1,         32'd2,  64'h0000_0000_FFFF_FFFF});
    vecs.push_back('{"and",     OpAnd,  32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_F000_F000});
    vecs.push_back('{"or",      OpOr,   32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_FFF0_FFF0});
    vecs.push_back('{"shl31",   OpShl,  32'd1,         32'd31, 64'h0000_0000_8000_0000});
    vecs.push_back('{"shl_amt", OpShl,  32'hF,         32'h24, 64'h0000_0000_0000_00F0});
    vecs.push_back('{"ror1",    OpRor,  32'd1,         32'd1,  64'h0000_0000_8000_0000});
    vecs.push_back('{"rol1",    OpRol,  32'h8000_0000, 32'd1,  64'h0000_0000_0000_0001});
    vecs.push_back('{"ror0",    OpRor,  32'h1234_5678, 32'h20, 64'h0000_0000_1234_5678});
    vecs.push_back('{"neg",     OpNeg,  32'd7,         32'd1,  64'h0000_0000_FFFF_FFFF});
    vecs.push_back('{"not",     OpNot,  32'd7,         32'd0,  64'h0000_0000_FFFF_FFFF});
    vecs.push_back('{"op_1f",   5'h1F,  32'd7,         32'd9,  64'd0});
    vecs.push_back('{"op_00",   5'h00,  32'd7,         32'd9,  64'd0});
    foreach (vecs[i]) begin
      exp = vecs[i].exp;
      if (!MulDiv && (vecs[i].op == OpMul || vecs[i].op == OpDiv)) exp = 64'd0;
      run_alu(vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, dut.z_q, exp);
    end

    // mul result high word into HI
    run_alu(OpMul, 32'hFFFF_FFFE, 32'd3);
    Zhighout = 1; HIin = 1; tick();
    check("hi_from_zhigh", 64'(dut.hi_q), MulDiv ? 64'hFFFF_FFFF : 64'd0);

    // shr through the register file
    load_mdr(32'h12); MDRout = 1; Rin = 16'h0008; tick();
    load_mdr(32'h14); MDRout = 1; Rin = 16'h0020; tick();
    Rout = 16'h0008; Yin = 1; tick();
    Rout = 16'h0020; Zin = 1; opcode = OpShr; tick();
    Zlowout = 1; Rin = 16'h0002; tick();
    check("shr_reg_seq", 64'(dut.r_q[1]), 64'd0);

    // Random ALU ops, results routed through Zlow/Zhigh
    for (int t = 0; t < 250; t++) begin
      op = ($urandom_range(9) == 0) ? 5'($urandom) : ops[$urandom_range(12)];
      a  = $urandom;
      b  = ($urandom_range(7) == 0) ? 32'd0 : (($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(40)));
      if (op == OpDiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      exp = alu_ref(op, a, b);
      run_alu(op, a, b);
      check($sformatf("rand_z op=%0h a=%h b=%h", op, a, b), dut.z_q, exp);
      k = $urandom_range(15);
      Zlowout = 1; Rin = 16'(1 << k); LOin = 1; tick();
      check($sformatf("rand_zlow_r%0d", k), {dut.r_q[k], dut.lo_q}, {exp[31:0], exp[31:0]});
      Zhighout = 1; HIin = 1; tick();
      check("rand_zhigh_hi", 64'(dut.hi_q), 64'(exp[63:32]));
    end

    // Asynchronous reset in the middle of a cycle
    load_mdr(32'hDEAD_BEEF); MDRout = 1; Rin = 16'h0002; tick();
    check("pre_reset_r1", 64'(dut.r_q[1]), 64'hDEAD_BEEF);
    #2 clear_n = 0;
    #1;
    check("midreset_r1", 64'(dut.r_q[1]), 64'd0);
    check("midreset_mdr", 64'(dut.mdr_q), 64'd0);
    check("midreset_z", dut.z_q, 64'd0);
    check("midreset_hi_y", 64'(dut.hi_q | dut.y_q | dut.pc_q), 64'd0);
    Rout = 16'h0002; #1;
    check("midreset_bus_r1", 64'(dut.bus), 64'd0);
    Rout = '0; Mdatain = 32'h55; Read = 1; MDRin = 1;
    @(posedge Clock); #1;
    check("reset_overrides_load", 64'(dut.mdr_q), 64'd0);
    #2 clear_n = 1;
    tick();
    check("first_load_after_release", 64'(dut.mdr_q), 64'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL use positional port order as listed below. Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 clear_n  input  1  asynchronous active-low reset.
REQ-004 Mdatain  input  32  memory read data.
REQ-005 Read  input  1  MDR source select: 1 = Mdatain, 0 = bus.
REQ-006 IncPC  input  1  with PCin, PC increments instead of loading the bus.
REQ-007 Rin  input  16  bit i = load enable of general register Ri.
REQ-008 Rout  input  16  bit i = Ri drives the bus.
REQ-009 PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin  input  1 each  load enables, in this order.
REQ-010 PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout  input  1 each  bus-drive selects, in this order.
REQ-011 opcode  input  5  ALU operation select.

Function
REQ-012 SHALL contain 32-bit registers R0–R15, PC, IR, MAR, MDR, Y, HI and LO, plus a 64-bit Z split into Zhigh and Zlow.
REQ-013 Bus SHALL be a 32-bit combinational mux with this priority: MDRout > PCout > Zhighout > Zlowout > HIout > LOout > Cout > R0..R15 (lowest index first); no select active gives 0.
REQ-014 Cout SHALL drive IR[18:0] sign-extended to 32 bits.
REQ-015 Each register SHALL load on the rising edge when its enable is high; multiple Rin bits SHALL load the same bus value simultaneously; R0 is a normal register.
REQ-016 MDR SHALL load Mdatain when MDRin=1 and Read=1, and the bus when MDRin=1 and Read=0.
REQ-017 PC SHALL load PC+1 (mod 2^32) when PCin=1 and IncPC=1, and the bus when PCin=1 and IncPC=0.
REQ-018 ALU operand A is Y and operand B is the bus; Z SHALL capture the 64-bit result when Zin=1, with latency one edge.
REQ-019 Opcodes: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr (logical), 01000 shra, 01001 shl, 01010 ror, 01011 rol, 01111 mul, 10000 div, 10001 neg(B), 10010 not(B).
REQ-020 Single-width operations SHALL write Zlow and clear Zhigh; add and sub wrap mod 2^32.
REQ-021 Shift and rotate amount SHALL be B[4:0]; an amount of 0 SHALL pass A unchanged.
REQ-022 mul SHALL be signed 32x32→64 with Zhigh=high word and Zlow=low word.
REQ-023 div SHALL be signed, truncating toward zero, with Zlow=quotient and Zhigh=remainder (remainder takes the sign of the dividend).
REQ-024 Divide by zero SHALL give Zlow=FFFFFFFF and Zhigh=A.
REQ-025 Unlisted opcodes SHALL give Z=0.

Reset
REQ-026 clear_n low SHALL clear every register, including Z, to 0 immediately, regardless of Clock.
REQ-027 Reset SHALL override any load enable; the first load takes effect on the first rising edge after release.

Configuration
REQ-028 With macro DATAPATH_MULDIV_EN defined, mul and div SHALL be as in REQ-022 to REQ-024.
REQ-029 Without DATAPATH_MULDIV_EN, opcodes 01111 and 10000 SHALL give Z=0 and no multiplier or divider logic SHALL exist.

Structure
REQ-030 Opcode localparams, the 32-bit word type and the 64-bit result type SHALL live in package datapath_pkg.
REQ-031 The ALU SHALL be sub-module datapath_alu (inputs A, B, opcode; output 64-bit result).
REQ-032 Registers and the bus mux SHALL remain in datapath.

Verification
REQ-033 shr: MDR<-0x12 then R3; MDR<-0x14 then R5; R3out+Yin; R5out+Zin with opcode 00111; Zlowout+R1in -> R1=0x00000000.
REQ-034 shr by 4: Y=0x80000012, B=4, opcode 00111 -> Zlow=0x08000001; opcode 01000 (shra) -> Zlow=0xF8000001.
REQ-035 PC sequence: PCout+MARin -> MAR=0; then PCin+IncPC -> PC=1; then MDRin+Read with Mdatain=0x28918000, then MDRout+IRin -> IR=0x28918000.
REQ-036 mul: Y=0xFFFFFFFE, B=3, opcode 01111 -> Z=0xFFFFFFFF_FFFFFFFA; Zhighout+HIin -> HI=0xFFFFFFFF.
REQ-037 div: Y=-7, B=2 -> Zlow=0xFFFFFFFD, Zhigh=0xFFFFFFFF; Y=5, B=0 -> Zlow=0xFFFFFFFF, Zhigh=5.
REQ-038 Reset mid-operation: clear_n low between edges -> all registers read 0 at once, and Rout with R1 selected drives 0.
